// File: rtl/morph_filter_if.sv
// Pixel stream bundle for morph_filter: run-time mode and the input stream,
// plus the filtered output stream with its raster coordinates.
interface morph_filter_if;
    logic        mode;
    logic        in_valid;
    logic        in_sof;
    logic        in_pix;
    logic        out_valid;
    logic [10:0] out_hpos;
    logic [10:0] out_vpos;
    logic        out_pix;

    modport master (
        output mode, in_valid, in_sof, in_pix,
        input  out_valid, out_hpos, out_vpos, out_pix
    );

    modport slave (
        input  mode, in_valid, in_sof, in_pix,
        output out_valid, out_hpos, out_vpos, out_pix
    );
endinterface

// File: rtl/morph_filter.sv
// Streaming binary dilate/erode over a WIN_SIZE x WIN_SIZE structuring element,
// with border padding, SOF raster tracking and a per-frame latched mode.
module morph_filter #(
    parameter int H_IMG_RES = 640,
    parameter int V_IMG_RES = 480,
    parameter int WIN_SIZE  = 5,
    parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'h0EFFFEE
) (
    input logic           clk,
    input logic           rst,
    morph_filter_if.slave bus
);

    // state    | meaning
    // WAIT_SOF | idle after reset, ignores pixels until a start of frame
    // PRIME    | filling line buffers, R*H_IMG_RES+R accepts before the first output
    // RUN      | one output per accepted input, raster delayed by R lines + R pixels

    localparam int R         = WIN_SIZE / 2;
    localparam int PRIME_LEN = R * H_IMG_RES + R;
    localparam int PW        = $clog2(PRIME_LEN + 1);
    localparam int XW        = $clog2(H_IMG_RES);
    localparam int SE_N      = WIN_SIZE * WIN_SIZE;
    localparam int SEW       = $clog2(SE_N);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          acc;
    logic          emit;
    logic          prime_done;
    logic [PW-1:0] prime_cnt;

    logic [10:0]   cnt_x;
    logic [10:0]   cnt_y;
    logic [10:0]   pos_x;
    logic [10:0]   pos_y;
    logic [XW-1:0] col_idx;

    logic [H_IMG_RES-1:0] line_buf [WIN_SIZE-1];
    logic [WIN_SIZE-1:0]  new_col;
    logic [WIN_SIZE-1:0]  hist    [WIN_SIZE-1];
    logic [WIN_SIZE-1:0]  win_nxt [WIN_SIZE];

    int   cx_i;
    int   cy_i;
    logic frame_start;
    logic mode_q;
    logic mode_eff;
    logic tap;
    logic res;

    // An SOF is the only way out of WAIT_SOF, so stray pixels there are dropped.
    assign acc = bus.in_valid && !rst && ((state != WAIT_SOF) || bus.in_sof);

    assign pos_x   = bus.in_sof ? '0 : cnt_x;
    assign pos_y   = bus.in_sof ? '0 : cnt_y;
    assign col_idx = pos_x[XW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (acc) begin
            if (pos_x == 11'(H_IMG_RES - 1)) begin
                cnt_x <= '0;
                cnt_y <= (pos_y == 11'(V_IMG_RES - 1)) ? '0 : pos_y + 11'd1;
            end else begin
                cnt_x <= pos_x + 11'd1;
                cnt_y <= pos_y;
            end
        end
    end

    // Remaining accepts before RUN; reloaded by every SOF so a restart re-primes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (acc) begin
            if (bus.in_sof) begin
                prime_cnt <= PW'(PRIME_LEN - 1);
            end else if (prime_cnt != '0) begin
                prime_cnt <= prime_cnt - PW'(1);
            end
        end
    end

    assign prime_done = (prime_cnt == PW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SOF: if (acc) state_nxt = PRIME;
            PRIME:    if (acc && !bus.in_sof && prime_done) state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = WAIT_SOF;
        endcase
    end

    always_comb begin
        emit = 1'b0;
        case (state)
            RUN:     emit = acc;
            default: emit = 1'b0;
        endcase
    end

    // Column-aligned cascade: each accept pushes the pixel down one line at its column.
    always_ff @(posedge clk) begin
        if (acc) begin
            line_buf[0][col_idx] <= bus.in_pix;
            for (int k = 1; k < WIN_SIZE - 1; k++) begin
                line_buf[k][col_idx] <= line_buf[k-1][col_idx];
            end
        end
    end

    always_comb begin
        new_col = '0;
        new_col[WIN_SIZE-1] = bus.in_pix;
        for (int k = 0; k < WIN_SIZE - 1; k++) begin
            new_col[WIN_SIZE-2-k] = line_buf[k][col_idx];
        end
    end

    // Row 0 of a column is the oldest line, column WIN_SIZE-1 the newest pixel.
    always_comb begin
        for (int c = 0; c < WIN_SIZE - 1; c++) begin
            win_nxt[c] = hist[c];
        end
        win_nxt[WIN_SIZE-1] = new_col;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int c = 0; c < WIN_SIZE - 1; c++) begin
                hist[c] <= win_nxt[c+1];
            end
        end
    end

    // Centre pixel trails the accepted input by R lines and R pixels, modulo the frame.
    always_comb begin
        cx_i = int'(pos_x) - R;
        cy_i = int'(pos_y) - R;
        if (cx_i < 0) begin
            cx_i = cx_i + H_IMG_RES;
            cy_i = cy_i - 1;
        end
        if (cy_i < 0) begin
            cy_i = cy_i + V_IMG_RES;
        end
    end

    assign frame_start = (cx_i == 0) && (cy_i == 0);
    assign mode_eff    = frame_start ? bus.mode : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (emit && frame_start) begin
            mode_q <= bus.mode;
        end
    end

    // Out-of-image taps take the identity of the operation, so borders never wrap.
    always_comb begin
        res = mode_eff;
        tap = 1'b0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                if (STRUCT_ELM[SEW'(SE_N - 1 - (r * WIN_SIZE + c))]) begin
                    if ((cy_i + r - R >= 0) && (cy_i + r - R < V_IMG_RES) &&
                        (cx_i + c - R >= 0) && (cx_i + c - R < H_IMG_RES)) begin
                        tap = win_nxt[c][r];
                    end else begin
                        tap = mode_eff;
                    end
                    res = mode_eff ? (res & tap) : (res | tap);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_pix   <= 1'b0;
            bus.out_hpos  <= '0;
            bus.out_vpos  <= '0;
        end else begin
            bus.out_valid <= emit;
            if (emit) begin
                bus.out_pix  <= res;
                bus.out_hpos <= 11'(cx_i);
                bus.out_vpos <= 11'(cy_i);
            end
        end
    end

endmodule

// File: tb/tb_morph_filter.sv
// Scoreboard bench for morph_filter on a 16x12 frame with a 5x5 disk element.
module tb_morph_filter;

    localparam int H = 16;
    localparam int V = 12;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        p;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morph_filter_if bus();

    morph_filter #(.H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    int          ones_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ones_run = 0;
    bit          img [V][H];
    bit          ef  [V][H];
    logic [24:0] se_bits;

    // Monitor: pops one expected pixel per output and checks per-frame one counts.
    initial begin
        exp_t e;
        int   want;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got (%0d,%0d)=%0d, expected no output",
                             bus.out_hpos, bus.out_vpos, bus.out_pix);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_hpos !== e.x || bus.out_vpos !== e.y || bus.out_pix !== e.p) begin
                        n_fail++;
                        $display("FAIL pixel: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                                 bus.out_hpos, bus.out_vpos, bus.out_pix, e.x, e.y, e.p);
                    end
                    if (e.x == 0 && e.y == 0) ones_run = 0;
                    if (bus.out_pix === 1'b1) ones_run++;
                    if (e.x == 11'(H - 1) && e.y == 11'(V - 1) && ones_q.size() != 0) begin
                        want = ones_q.pop_front();
                        n_checks++;
                        if (ones_run != want) begin
                            n_fail++;
                            $display("FAIL frame_ones: got %0d, expected %0d", ones_run, want);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_px(input bit sof, input bit pix, input bit gaps, input bit tog);
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
                bus.in_pix   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        if (tog) bus.mode = ~bus.mode;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pix   = pix;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int n_px, input bit gaps, input int tog_at);
        for (int i = 0; i < n_px; i++) begin
            drive_px(i == 0, img[i / H][i % H], gaps, i == tog_at);
        end
    endtask

    task automatic push_exp(input int n_px, input bit with_count);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < n_px; i++) begin
            e.x = 11'(i % H);
            e.y = 11'(i / H);
            e.p = ef[i / H][i % H];
            if (e.p) ones++;
            exp_q.push_back(e);
        end
        if (with_count) ones_q.push_back(ones);
    endtask

    task automatic set_all(input bit iv, input bit ev);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                img[y][x] = iv;
                ef[y][x]  = ev;
            end
    endtask

    // Hand rule: a disk around one set pixel (no corners), clipped at the border.
    task automatic exp_point(input int px, input int py);
        int dx, dy;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                dx = (x > px) ? x - px : px - x;
                dy = (y > py) ? y - py : py - y;
                ef[y][x] = (dx <= 2) && (dy <= 2) && !(dx == 2 && dy == 2);
            end
    endtask

    task automatic block_img();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = (x >= 4 && x <= 10 && y >= 3 && y <= 9);
    endtask

    task automatic exp_block_erode();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                ef[y][x] = (x >= 6 && x <= 8 && y >= 5 && y <= 7);
    endtask

    task automatic exp_block_dilate();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                ef[y][x] = (x >= 2 && x <= 12 && y >= 1 && y <= 11) &&
                           !((x == 2 || x == 12) && (y == 1 || y == 11));
    endtask

    // Whole-frame reference used for the random frames.
    task automatic model_frame(input bit m);
        bit acc_v, v;
        int xx, yy;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                acc_v = m;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        if (se_bits[24 - (r * 5 + c)]) begin
                            yy = y + r - 2;
                            xx = x + c - 2;
                            v = (yy >= 0 && yy < V && xx >= 0 && xx < H) ? img[yy][xx] : m;
                            acc_v = m ? (acc_v & v) : (acc_v | v);
                        end
                ef[y][x] = acc_v;
            end
    endtask

    task automatic rand_img(input int density);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = ($urandom_range(0, 99) < density);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pix !== 1'b0 ||
            bus.out_hpos !== 11'd0 || bus.out_vpos !== 11'd0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0d pix=%0d hpos=%0d vpos=%0d, expected all 0",
                     name, bus.out_valid, bus.out_pix, bus.out_hpos, bus.out_vpos);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d pending outputs, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        se_bits      = 25'h0EFFFEE;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // single pixel dilate, centre and corner
        set_all(0, 0); img[6][8] = 1; exp_point(8, 6);
        bus.mode = 1'b0; push_exp(H * V, 1); send_frame(H * V, 0, -1);
        set_all(0, 0); img[0][0] = 1; exp_point(0, 0);
        push_exp(H * V, 1); send_frame(H * V, 0, -1);

        // block erode
        block_img(); exp_block_erode();
        bus.mode = 1'b1; push_exp(H * V, 1); send_frame(H * V, 0, -1);

        // border padding: erode all-ones, dilate all-zeros
        set_all(1, 1);
        push_exp(H * V, 1); send_frame(H * V, 0, -1);
        set_all(0, 0);
        bus.mode = 1'b0; push_exp(H * V, 1); send_frame(H * V, 0, -1);

        // mode toggled at the input that yields output (5,5)
        block_img(); exp_block_dilate();
        push_exp(H * V, 1); send_frame(H * V, 0, 7 * H + 7);
        exp_block_erode();
        push_exp(H * V, 1); send_frame(H * V, 0, -1);

        set_all(1, 1);
        send_frame(34, 0, -1);
        idle(5);
        check_drained("drain_directed");

        // gaps, mid-frame reset, re-prime
        rst = 1'b1; idle(2); rst = 1'b0;
        bus.mode = 1'b1;
        rand_img(75); model_frame(1);
        push_exp(66, 0); send_frame(100, 1, -1);
        idle(3);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_hpos !== 11'd1 || bus.out_vpos !== 11'd4) begin
            n_fail++;
            $display("FAIL hold_on_gap: got valid=%0d hpos=%0d vpos=%0d, expected 0 1 4",
                     bus.out_valid, bus.out_hpos, bus.out_vpos);
        end
        check_drained("drain_before_reset");

        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_pix = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");

        for (int i = 0; i < 20; i++) drive_px(0, 1, 1, 0);

        rand_img(75); model_frame(1);
        push_exp(H * V, 1); send_frame(H * V, 1, -1);
        bus.mode = 1'b0;
        rand_img(20); model_frame(0);
        push_exp(H * V, 1); send_frame(H * V, 1, -1);
        set_all(1, 1);
        send_frame(34, 1, -1);
        idle(5);
        check_drained("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
